// File: rtl/square_composer_pkg.sv
// Shared types and width helpers for the square composer.
// The composer rebuilds a radicand from an integer root and its remainder.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32'd4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // The step counter must exist even when a single root bit is processed.
  function automatic int cnt_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

  function automatic int rad_width(input int width);
    return 2 * width;
  endfunction

  function automatic int rem_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/square_composer_if.sv
// Operand/result handshake bundle between a producer of (root, remainder)
// pairs and the square composer.
interface square_composer_if #(
  parameter int WIDTH = 4
);
  logic                   din_valid;
  logic                   din_ready;
  logic [WIDTH-1:0]       root;
  logic [WIDTH:0]         remainder;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [2*WIDTH-1:0]     radicand;
  logic                   invalid;

  modport master (
    output din_valid, root, remainder, dout_ready,
    input  din_ready, dout_valid, radicand, invalid
  );

  modport slave (
    input  din_valid, root, remainder, dout_ready,
    output din_ready, dout_valid, radicand, invalid
  );

  modport monitor (
    input din_valid, din_ready, root, remainder,
    input dout_valid, dout_ready, radicand, invalid
  );
endinterface

// File: rtl/square_composer_chk.sv
// Protocol checker for the square composer: no simultaneous input/output
// readiness, and results held steady while the consumer stalls.
module square_composer_chk #(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 din_ready,
  input logic                 dout_valid,
  input logic                 dout_ready,
  input logic [2*WIDTH-1:0]   radicand,
  input logic                 invalid
);

  logic                 hold_r;
  logic [2*WIDTH-1:0]   rad_prev_r;
  logic                 inv_prev_r;

  // Remember whether the previous cycle was a stalled result and what it showed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r     <= 1'b0;
      rad_prev_r <= '0;
      inv_prev_r <= 1'b0;
    end else begin
      hold_r     <= dout_valid && !dout_ready;
      rad_prev_r <= radicand;
      inv_prev_r <= invalid;
    end
  end

  // Protocol properties, evaluated on pre-update values at each edge.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(din_ready && dout_valid));
      if (hold_r) begin
        assert (dout_valid && (radicand == rad_prev_r) && (invalid == inv_prev_r));
      end
    end
  end

endmodule

// File: rtl/square_composer.sv
// Iterative squaring engine: radicand = root*root + remainder, one root bit
// per cycle, with a flag for pairs no exact integer square root could yield.
module square_composer
  import square_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  square_composer_if.slave bus
);

  localparam int RAD_W = rad_width(WIDTH);
  localparam int REM_W = rem_width(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_r;
  logic [WIDTH-1:0]   root_r;
  logic [RAD_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               inv_flag_r;
  logic               din_ready_r;
  logic               dout_valid_r;
  logic [RAD_W-1:0]   radicand_r;
  logic               invalid_r;

  logic               root_bit_s;
  logic               last_step_s;
  logic [RAD_W-1:0]   partial_s;
  logic [RAD_W-1:0]   acc_next_s;
  logic               rem_too_big_s;
  logic [RAD_W-1:0]   acc_init_s;

  // Shift-add step: add root << cnt when the current root bit is set.
  always_comb begin
    root_bit_s            = root_r[cnt_r];
    last_step_s           = (cnt_r == CNT_W'(WIDTH - 1));
    partial_s             = '0;
    partial_s[WIDTH-1:0]  = root_r;
    partial_s             = partial_s << cnt_r;
    if (root_bit_s) begin
      acc_next_s = acc_r + partial_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Input-side decode; the compare is one bit wider than 2*root so it never overflows.
  always_comb begin
    rem_too_big_s = ({1'b0, bus.remainder} > {1'b0, bus.root, 1'b0});
    acc_init_s    = RAD_W'(bus.remainder);
  end

  // Control FSM plus datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      root_r       <= '0;
      acc_r        <= '0;
      cnt_r        <= '0;
      inv_flag_r   <= 1'b0;
      din_ready_r  <= 1'b1;
      dout_valid_r <= 1'b0;
      radicand_r   <= '0;
      invalid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.din_valid && din_ready_r) begin
            root_r      <= bus.root;
            acc_r       <= acc_init_s;
            inv_flag_r  <= rem_too_big_s;
            cnt_r       <= '0;
            din_ready_r <= 1'b0;
            state_r     <= CALC;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          // The final add is captured straight into the output register.
          if (last_step_s) begin
            radicand_r   <= acc_next_s;
            invalid_r    <= inv_flag_r;
            dout_valid_r <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (bus.dout_ready) begin
            dout_valid_r <= 1'b0;
            din_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          dout_valid_r <= 1'b0;
          din_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.radicand   = radicand_r;
  assign bus.invalid    = invalid_r;

  square_composer_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_ready  (din_ready_r),
    .dout_valid (dout_valid_r),
    .dout_ready (bus.dout_ready),
    .radicand   (radicand_r),
    .invalid    (invalid_r)
  );

endmodule

// File: tb/tb_square_composer.sv
// Self-checking bench for square_composer (WIDTH=4) against an arithmetic
// reference: radicand = (root^2 + rem) mod 256, invalid = rem > 2*root.
module tb_square_composer;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  square_composer_if #(.WIDTH(W)) bus ();

  square_composer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic int model_rad(input int r, input int m);
    return (r * r + m) % 256;
  endfunction

  function automatic bit model_inv(input int r, input int m);
    return m > 2 * r;
  endfunction

  function automatic int isqrt(input int v);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  // Drive one operation and collect its result; timeout set if a bound expires.
  task automatic run_op(input int r, input int m, input int gap, input int stall,
                        output logic [7:0] rad, output logic inv, output bit timeout);
    int n;
    timeout = 1'b0;
    rad = 8'd0;
    inv = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b1;
    bus.root      = r[3:0];
    bus.remainder = m[4:0];
    n = 0;
    while (!bus.din_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.root      = 4'($urandom);
    bus.remainder = 5'($urandom);
    n = 0;
    while (!bus.dout_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rad = bus.radicand;
    inv = bus.invalid;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.din_ready !== 1'b1) begin
      failures++; $display("FAIL reset_din_ready got=%b exp=1", bus.din_ready);
    end
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      failures++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid);
    end
    checks++;
    if (bus.radicand !== 8'd0 || bus.invalid !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got rad=%0d inv=%b exp rad=0 inv=0", bus.radicand, bus.invalid);
    end
  endtask

  task automatic test_basic_timing();
    bus.root = 4'd5; bus.remainder = 5'd3; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    checks++;
    if (bus.din_ready !== 1'b0 || bus.dout_valid !== 1'b0) begin
      failures++; $display("FAIL basic_after_accept got rdy=%b vld=%b exp rdy=0 vld=0", bus.din_ready, bus.dout_valid);
    end
    for (int e = 1; e <= W; e++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dout_valid !== (e == W) || bus.din_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_latency edge=k+%0d got vld=%b rdy=%b exp vld=%b rdy=0", e, bus.dout_valid, bus.din_ready, (e == W));
      end
    end
    checks++;
    if (bus.radicand !== 8'd28 || bus.invalid !== 1'b0) begin
      failures++; $display("FAIL basic_result got rad=%0d inv=%b exp rad=28 inv=0", bus.radicand, bus.invalid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
      failures++; $display("FAIL basic_return_idle got vld=%b rdy=%b exp vld=0 rdy=1", bus.dout_valid, bus.din_ready);
    end
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_directed_values();
    int tr[6] = '{15, 0, 3, 3, 15, 0};
    int tm[6] = '{30, 0, 7, 6, 31, 1};
    logic [7:0] rad;
    logic inv;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(tr[i], tm[i], 1, 0, rad, inv, to);
      checks++;
      if (to || rad !== 8'(model_rad(tr[i], tm[i])) || inv !== model_inv(tr[i], tm[i])) begin
        failures++;
        $display("FAIL directed root=%0d rem=%0d got rad=%0d inv=%b to=%b exp rad=%0d inv=%b",
                 tr[i], tm[i], rad, inv, to, model_rad(tr[i], tm[i]), model_inv(tr[i], tm[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.root = 4'd9; bus.remainder = 5'd2; bus.din_valid = 1'b1; bus.dout_ready = 1'b0;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    n = 0;
    while (!bus.dout_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      failures++; $display("FAIL backpressure_timeout got no dout_valid within 50 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.radicand !== 8'd83 || bus.din_ready !== 1'b0 || bus.invalid !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got vld=%b rad=%0d rdy=%b inv=%b exp vld=1 rad=83 rdy=0 inv=0",
                 i, bus.dout_valid, bus.radicand, bus.din_ready, bus.invalid);
      end
      bus.root = 4'($urandom); bus.remainder = 5'($urandom); bus.din_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
      failures++; $display("FAIL backpressure_release got vld=%b rdy=%b exp vld=0 rdy=1", bus.dout_valid, bus.din_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] rad;
    logic inv;
    bit to;
    bus.root = 4'd7; bus.remainder = 5'd1; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.radicand !== 8'd0) begin
      failures++;
      $display("FAIL midreset_state got rdy=%b vld=%b rad=%0d exp rdy=1 vld=0 rad=0", bus.din_ready, bus.dout_valid, bus.radicand);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dout_valid !== 1'b0) begin
        failures++; $display("FAIL midreset_dropped cyc=%0d got vld=%b exp vld=0", i, bus.dout_valid);
      end
    end
    bus.dout_ready = 1'b0;
    run_op(2, 0, 0, 0, rad, inv, to);
    checks++;
    if (to || rad !== 8'd4 || inv !== 1'b0) begin
      failures++; $display("FAIL midreset_next got rad=%0d inv=%b to=%b exp rad=4 inv=0", rad, inv, to);
    end
  endtask

  task automatic test_random_pairs();
    logic [7:0] rad;
    logic inv;
    bit to;
    int r, m;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      m = $urandom_range(0, 31);
      run_op(r, m, $urandom_range(0, 2), $urandom_range(0, 2), rad, inv, to);
      checks++;
      if (to || rad !== 8'(model_rad(r, m)) || inv !== model_inv(r, m)) begin
        failures++;
        $display("FAIL random_pair root=%0d rem=%0d got rad=%0d inv=%b to=%b exp rad=%0d inv=%b",
                 r, m, rad, inv, to, model_rad(r, m), model_inv(r, m));
      end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] rad;
    logic inv;
    bit to;
    int v, s;
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(0, 255);
      s = isqrt(v);
      run_op(s, v - s * s, $urandom_range(0, 3), $urandom_range(0, 3), rad, inv, to);
      checks++;
      if (to || rad !== 8'(v) || inv !== 1'b0) begin
        failures++;
        $display("FAIL round_trip r=%0d root=%0d rem=%0d got rad=%0d inv=%b to=%b exp rad=%0d inv=0",
                 v, s, v - s * s, rad, inv, to, v);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    bus.root = 4'd0;
    bus.remainder = 5'd0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_basic_timing();
    test_directed_values();
    test_backpressure();
    test_reset_mid_op();
    test_random_pairs();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/square_composer.md
Name: square_composer

Overview:
- Inverse of the team's pipelined square-root extractor: takes an integer root and remainder and rebuilds the radicand, radicand = root*root + remainder.
- Iterative shift-add, one root bit per cycle, valid/ready handshake on both sides.
- Used as a round-trip checker and as a squaring engine in the basic-compute library.
- Also flags (root, remainder) pairs that no exact integer square root could produce (remainder > 2*root).

Parameters:
- WIDTH, 4, root width in bits. Radicand is 2*WIDTH bits; remainder is WIDTH+1 bits.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- din_valid  input  1  root/remainder valid
- din_ready  output  1  block can accept input
- root  input  WIDTH  square root operand
- remainder  input  WIDTH+1  remainder operand
- dout_valid  output  1  result valid
- dout_ready  input  1  consumer accepts result
- radicand  output  2*WIDTH  root*root + remainder, modulo 2^(2*WIDTH)
- invalid  output  1  remainder > 2*root for this result

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge): state IDLE, din_ready=1, dout_valid=0, radicand=0, invalid=0, step counter=0. Reset overrides everything, including mid-CALC or DONE. Any in-flight operation is silently dropped.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - din_ready=1, dout_valid=0.
  - On din_valid && din_ready at edge k:
    - latch root;
    - acc <= zero-extended remainder;
    - invalid_r <= (remainder > 2*root), compared at WIDTH+2 bits so nothing overflows;
    - cnt <= 0;
    - go to CALC.
- CALC:
  - din_ready=0, dout_valid=0.
  - Each edge: if root[cnt]==1 then acc <= acc + (root << cnt), truncated to 2*WIDTH bits; cnt <= cnt+1.
  - When cnt == WIDTH-1, that edge performs the last add and moves to DONE.
  - Exactly WIDTH CALC edges (k+1..k+WIDTH).
- DONE:
  - dout_valid=1; radicand=acc and invalid=invalid_r, both held stable while dout_ready=0.
  - On dout_valid && dout_ready at an edge, go to IDLE.
  - din_ready stays 0 in DONE, so there is no accept in the same cycle as the output handshake.
- Latency: dout_valid first high in the cycle after edge k+WIDTH. Minimum spacing between accepts is WIDTH+2 cycles.
- Outputs are registered. radicand and invalid keep their last value after leaving DONE and are meaningful only while dout_valid=1.
- Arithmetic:
  - For valid pairs, max result is (2^WIDTH-1)^2 + 2*(2^WIDTH-1) = 2^(2*WIDTH)-1, which fits with no overflow.
  - Invalid pairs may wrap modulo 2^(2*WIDTH); the result is still produced, with invalid=1.
- din_valid may drop without acceptance (no input stability requirement outside the handshake edge). Inputs are ignored outside IDLE.
- WIDTH=1 is legal: a single CALC cycle.

Decomposition:
- Package square_pkg:
  - state enum {IDLE, CALC, DONE};
  - function clog2 for cnt width, with cnt width = max(1, clog2(WIDTH));
  - localparam helpers for RAD_W = 2*WIDTH and REM_W = WIDTH+1.
- No sub-module needed. The add step is a single expression in the datapath; FSM and datapath live in one always block pair.

Test Plan (WIDTH=4):
- root=5, rem=3, dout_ready=1 -> radicand=28, invalid=0; dout_valid first high in the cycle after edge k+4; din_ready low for cycles k+1..k+5.
- root=15, rem=30 -> radicand=255, invalid=0 (max value, no overflow). root=0, rem=0 -> radicand=0, invalid=0.
- root=3, rem=7 (7 > 6) -> invalid=1, radicand=16. Then root=3, rem=6 -> invalid=0, radicand=15.
- Backpressure: root=9, rem=2 with dout_ready=0 for 10 cycles -> dout_valid and radicand=83 held stable, din_ready=0 throughout; dout_ready=1 -> IDLE next cycle, din_ready=1.
- Reset mid-operation: accept root=7, rem=1, assert rst_n=0 at edge k+2 -> next cycle IDLE, din_ready=1, dout_valid=0, radicand=0. New input root=2, rem=0 -> radicand=4.
- Round-trip: 200 random radicands r; model root=floor(sqrt(r)), rem=r-root^2; random din_valid/dout_ready gaps -> radicand==r and invalid=0 for all.
